// File: rtl/mux_sel_arbiter_pkg.sv
// rtl/mux_sel_arbiter_pkg.sv - shared types and helpers for the mux select arbiter
package mux_sel_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - rotating-priority winner search over eight requests
module rr_pick8
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0]     start;
    logic [SEL_W-1:0]     offs;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    // Rotate so the slot after ptr sits at bit 0; the last owner lands at bit 7.
    always_comb begin
        start = ptr + 3'd1;
        dbl   = {req, req} >> start;
        rot   = dbl[NUM_REQ-1:0];
        found = |req;
        offs  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = SEL_W'(i);
            end
        end
        idx = start + offs;
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin owner of the 8:1 mux select with per-grant burst limit
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         req,
    input  logic               out_ready,
    output logic [7:0]         grant,
    output logic               C2,
    output logic               C1,
    output logic               C0,
    output logic               out_valid,
    output logic [CNT_W-1:0]   beat_cnt
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_t         state, state_next;
    logic [SEL_W-1:0]   sel, sel_next;
    logic [SEL_W-1:0]   ptr, ptr_next;
    logic [7:0]         grant_next;
    logic [CNT_W-1:0]   cnt_next;

    logic               found;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   pick_ptr;
    logic               accept;
    logic               grant_end;

    // While granting, the search must already treat the current owner as last.
    assign pick_ptr  = (state == GRANT) ? sel : ptr;
    assign accept    = out_valid & out_ready;
    assign grant_end = (state == GRANT) &&
                       ((accept && (beat_cnt == BURST_LAST)) || !req[sel]);

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= 3'd7;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            sel      <= sel_next;
            ptr      <= ptr_next;
            beat_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        sel_next   = sel;
        ptr_next   = ptr;
        cnt_next   = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    grant_next = onehot8(idx);
                    sel_next   = idx;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_next = sel;
                    cnt_next = '0;
                    if (found) begin
                        grant_next = onehot8(idx);
                        sel_next   = idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else if (accept) begin
                    cnt_next = beat_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == GRANT) && req[sel];
        C2        = sel[2];
        C1        = sel[1];
        C0        = sel[0];
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - scoreboard bench for the mux select arbiter
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       reset, out_ready, out_valid, C2, C1, C0;
    logic [7:0] req, grant;
    logic [3:0] beat_cnt;

    logic       reset1, out_ready1, out_valid1, C2_1, C1_1, C0_1;
    logic [7:0] req1, grant1;
    logic [3:0] beat_cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rst;
        logic [7:0]  rq;
        logic        rdy;
        logic [15:0] exp;
    } step_t;

    step_t sb[$];
    step_t st;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.BURST_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
        .grant(grant), .C2(C2), .C1(C1), .C0(C0),
        .out_valid(out_valid), .beat_cnt(beat_cnt)
    );

    mux_sel_arbiter #(.BURST_MAX(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset1), .req(req1), .out_ready(out_ready1),
        .grant(grant1), .C2(C2_1), .C1(C1_1), .C0(C0_1),
        .out_valid(out_valid1), .beat_cnt(beat_cnt1)
    );

    function automatic void push(input logic r, input logic [7:0] q, input logic y,
                                 input logic [7:0] g, input logic [2:0] s,
                                 input logic [3:0] c, input logic v);
        sb.push_back({r, q, y, g, s, c, v});
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_rr();
        int n = 0;
        push(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        push(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        for (int k = 0; k < 9; k++)
            for (int b = 0; b < 4; b++)
                push(1'b0, 8'hFF, 1'b1, 8'h01 << (k % 8), 3'(k % 8), 4'(b), 1'b1);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            reset = st.rst; req = st.rq; out_ready = st.rdy;
            cyc();
            checks++;
            if ({grant, C2, C1, C0, beat_cnt, out_valid} !== st.exp) begin
                errors++;
                $display("FAIL reset_rr step %0d: got %h expected %h", n,
                         {grant, C2, C1, C0, beat_cnt, out_valid}, st.exp);
            end
            n++;
        end
    endtask

    task automatic test_stall();
        int n = 0;
        push(1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        push(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 4'd0, 1'b1);
        push(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 4'd1, 1'b1);
        push(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 4'd2, 1'b1);
        for (int i = 0; i < 10; i++)
            push(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 4'd2, 1'b1);
        push(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 4'd3, 1'b1);
        push(1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 4'd0, 1'b1);
        push(1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 4'd0, 1'b0);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            reset = st.rst; req = st.rq; out_ready = st.rdy;
            cyc();
            checks++;
            if ({grant, C2, C1, C0, beat_cnt, out_valid} !== st.exp) begin
                errors++;
                $display("FAIL stall step %0d: got %h expected %h", n,
                         {grant, C2, C1, C0, beat_cnt, out_valid}, st.exp);
            end
            n++;
        end
    endtask

    task automatic test_early_release();
        int n = 0;
        push(1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        push(1'b0, 8'h28, 1'b1, 8'h08, 3'd3, 4'd0, 1'b1);
        push(1'b0, 8'h28, 1'b1, 8'h08, 3'd3, 4'd1, 1'b1);
        push(1'b0, 8'h28, 1'b1, 8'h08, 3'd3, 4'd2, 1'b1);
        push(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 4'd0, 1'b1);
        push(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 4'd1, 1'b1);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            reset = st.rst; req = st.rq; out_ready = st.rdy;
            cyc();
            checks++;
            if ({grant, C2, C1, C0, beat_cnt, out_valid} !== st.exp) begin
                errors++;
                $display("FAIL early_release step %0d: got %h expected %h", n,
                         {grant, C2, C1, C0, beat_cnt, out_valid}, st.exp);
            end
            n++;
        end
    endtask

    task automatic test_sole_requester();
        int n = 0;
        push(1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        for (int b = 0; b < 6; b++)
            push(1'b0, 8'h40, 1'b1, 8'h40, 3'd6, 4'(b % 4), 1'b1);
        push(1'b0, 8'h00, 1'b1, 8'h00, 3'd6, 4'd0, 1'b0);
        push(1'b0, 8'h00, 1'b1, 8'h00, 3'd6, 4'd0, 1'b0);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            reset = st.rst; req = st.rq; out_ready = st.rdy;
            cyc();
            checks++;
            if ({grant, C2, C1, C0, beat_cnt, out_valid} !== st.exp) begin
                errors++;
                $display("FAIL sole_requester step %0d: got %h expected %h", n,
                         {grant, C2, C1, C0, beat_cnt, out_valid}, st.exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        push(1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        push(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 4'd0, 1'b1);
        push(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 4'd1, 1'b1);
        push(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 4'd2, 1'b1);
        push(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        push(1'b0, 8'hFF, 1'b1, 8'h01, 3'd0, 4'd0, 1'b1);
        push(1'b0, 8'hFF, 1'b1, 8'h01, 3'd0, 4'd1, 1'b1);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            reset = st.rst; req = st.rq; out_ready = st.rdy;
            cyc();
            checks++;
            if ({grant, C2, C1, C0, beat_cnt, out_valid} !== st.exp) begin
                errors++;
                $display("FAIL reset_mid_burst step %0d: got %h expected %h", n,
                         {grant, C2, C1, C0, beat_cnt, out_valid}, st.exp);
            end
            n++;
        end
    endtask

    task automatic test_burst_one();
        int n = 0;
        push(1'b1, 8'h81, 1'b1, 8'h00, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            push(1'b0, 8'h81, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h80,
                 (i % 2 == 0) ? 3'd0 : 3'd7, 4'd0, 1'b1);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            reset1 = st.rst; req1 = st.rq; out_ready1 = st.rdy;
            cyc();
            checks++;
            if ({grant1, C2_1, C1_1, C0_1, beat_cnt1, out_valid1} !== st.exp) begin
                errors++;
                $display("FAIL burst_one step %0d: got %h expected %h", n,
                         {grant1, C2_1, C1_1, C0_1, beat_cnt1, out_valid1}, st.exp);
            end
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; out_ready = 1'b1;
        reset1 = 1'b1; req1 = '0; out_ready1 = 1'b1;
        cyc();
        test_reset_rr();
        test_stall();
        test_early_release();
        test_sole_requester();
        test_reset_mid_burst();
        test_burst_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
